// File: rtl/nmr_acq_pkg.sv
// Shared definitions for the NMR acquisition capture path: one-hot FSM states
// and the layout of a FIFO word, packed as {eop, sop, data}.
package nmr_acq_pkg;

   typedef enum logic [3:0] {
      IDLE    = 4'b0001,
      ARMED   = 4'b0010,
      CAPTURE = 4'b0100,
      FLUSH   = 4'b1000
   } state_t;

   // Flag bit positions, counted upward from the top of the data field
   localparam int SOP_OFS = 0;
   localparam int EOP_OFS = 1;
   localparam int FLAG_W  = 2;

endpackage

// File: rtl/nmr_sync_fifo.sv
// Single-clock show-ahead FIFO; the head word reads as zero while empty so
// downstream outputs settle to zero without resetting the storage array.
module nmr_sync_fifo #(
   parameter int WIDTH   = 17,
   parameter int FIFO_AW = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [2**FIFO_AW];
   logic [FIFO_AW:0] wr_ptr;
   logic [FIFO_AW:0] rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                  (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign do_wr = wr_en & ~full;
   assign do_rd = rd_en & ~empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[FIFO_AW-1:0]] <= wr_data;
   end

   assign rd_data = empty ? '0 : mem[rd_ptr[FIFO_AW-1:0]];

endmodule

// File: rtl/nmr_acq_capture.sv
// Captures ADC samples inside the acquisition window, applies phase-cycle
// polarity, frames them per echo and streams them out through a FIFO.
module nmr_acq_capture
   import nmr_acq_pkg::*;
#(
   parameter int ADC_WIDTH      = 14,
   parameter int FIFO_AW        = 4,
   parameter int ECHO_CNT_WIDTH = 32
) (
   input  logic                      CLK,
   input  logic                      RESET_n,
   input  logic                      FSMSTAT,
   input  logic                      ACQ_WND,
   input  logic                      ADC_CLK,
   input  logic                      PHASE_CYC,
   input  logic [ADC_WIDTH-1:0]      ADC_DATA,
   output logic [ADC_WIDTH:0]        OUT_DATA,
   output logic                      OUT_SOP,
   output logic                      OUT_EOP,
   output logic                      OUT_VALID,
   input  logic                      OUT_READY,
   output logic [ECHO_CNT_WIDTH-1:0] ECHO_IDX,
   output logic                      OVERFLOW,
   input  logic                      CLR_OVF,
   output logic                      BUSY
);

   localparam int OW = ADC_WIDTH + 1;
   localparam int WW = OW + FLAG_W;

   // One extra bit of headroom lets the most-negative code negate cleanly
   function automatic logic signed [OW-1:0] sign_correct(
      input logic signed [ADC_WIDTH-1:0] s,
      input logic                        p
   );
      logic signed [OW-1:0] ext;
      ext = {s[ADC_WIDTH-1], s};
      return p ? ext : -ext;
   endfunction

   state_t                    state;
   state_t                    state_nxt;
   logic                      adc_clk_q;
   logic                      acq_q;
   logic                      fsm_q;
   logic                      pol;
   logic                      stg_valid;
   logic                      stg_sop;
   logic                      first_pend;
   logic signed [OW-1:0]      stg_data;
   logic [ECHO_CNT_WIDTH-1:0] echo_idx;
   logic                      ovf;
   logic                      sample_ev;
   logic                      acq_fall;
   logic                      fsm_rise;
   logic                      capture;
   logic                      push;
   logic                      push_eop;
   logic [WW-1:0]             push_word;
   logic [WW-1:0]             head;
   logic                      full;
   logic                      empty;

   assign sample_ev = ADC_CLK & ~adc_clk_q & ACQ_WND;
   assign acq_fall  = acq_q & ~ACQ_WND;
   assign fsm_rise  = FSMSTAT & ~fsm_q;
   assign capture   = (state == CAPTURE) && sample_ev;
   assign push_word = {push_eop, stg_sop, stg_data};

   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      push_eop  = 1'b0;
      unique case (state)
         IDLE: begin
            if (fsm_rise) state_nxt = ARMED;
         end
         ARMED: begin
            if (!FSMSTAT)     state_nxt = IDLE;
            else if (ACQ_WND) state_nxt = CAPTURE;
         end
         CAPTURE: begin
            if (acq_fall)                    state_nxt = FLUSH;
            else if (sample_ev && stg_valid) push      = 1'b1;
         end
         FLUSH: begin
            push      = stg_valid;
            push_eop  = 1'b1;
            state_nxt = ARMED;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state      <= IDLE;
         adc_clk_q  <= 1'b0;
         acq_q      <= 1'b0;
         fsm_q      <= 1'b0;
         pol        <= 1'b1;
         stg_valid  <= 1'b0;
         stg_sop    <= 1'b0;
         first_pend <= 1'b0;
         echo_idx   <= '0;
         ovf        <= 1'b0;
      end else begin
         state     <= state_nxt;
         adc_clk_q <= ADC_CLK;
         acq_q     <= ACQ_WND;
         fsm_q     <= FSMSTAT;
         if (state == IDLE && fsm_rise) begin
            pol      <= PHASE_CYC;
            echo_idx <= '0;
         end
         if (state == ARMED) first_pend <= 1'b1;
         if (capture) begin
            stg_valid  <= 1'b1;
            stg_sop    <= first_pend;
            first_pend <= 1'b0;
         end
         // A dropped eop word still closes its echo
         if (state == FLUSH) begin
            stg_valid <= 1'b0;
            if (stg_valid) echo_idx <= echo_idx + 1'b1;
         end
         if (push && full) ovf <= 1'b1;
         else if (CLR_OVF) ovf <= 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (capture) stg_data <= sign_correct(ADC_DATA, pol);
   end

   nmr_sync_fifo #(
      .WIDTH   (WW),
      .FIFO_AW (FIFO_AW)
   ) u_fifo (
      .clk     (CLK),
      .rst_n   (RESET_n),
      .wr_en   (push),
      .wr_data (push_word),
      .rd_en   (OUT_READY),
      .rd_data (head),
      .full    (full),
      .empty   (empty)
   );

   assign OUT_DATA  = head[OW-1:0];
   assign OUT_SOP   = head[OW+SOP_OFS];
   assign OUT_EOP   = head[OW+EOP_OFS];
   assign OUT_VALID = ~empty;
   assign ECHO_IDX  = echo_idx;
   assign OVERFLOW  = ovf;
   assign BUSY      = (state != IDLE);

endmodule

// File: tb/tb_nmr_acq_capture.sv
// Bench for nmr_acq_capture: table vectors, directed corner sequences and
// randomized scans scored against a queue-based stream model.
module tb_nmr_acq_capture;

   logic        CLK;
   logic        RESET_n;
   logic        FSMSTAT;
   logic        ACQ_WND;
   logic        ADC_CLK;
   logic        PHASE_CYC;
   logic [13:0] ADC_DATA;
   logic [14:0] OUT_DATA;
   logic        OUT_SOP;
   logic        OUT_EOP;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic [31:0] ECHO_IDX;
   logic        OVERFLOW;
   logic        CLR_OVF;
   logic        BUSY;

   nmr_acq_capture dut (
      .CLK       (CLK),
      .RESET_n   (RESET_n),
      .FSMSTAT   (FSMSTAT),
      .ACQ_WND   (ACQ_WND),
      .ADC_CLK   (ADC_CLK),
      .PHASE_CYC (PHASE_CYC),
      .ADC_DATA  (ADC_DATA),
      .OUT_DATA  (OUT_DATA),
      .OUT_SOP   (OUT_SOP),
      .OUT_EOP   (OUT_EOP),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .ECHO_IDX  (ECHO_IDX),
      .OVERFLOW  (OVERFLOW),
      .CLR_OVF   (CLR_OVF),
      .BUSY      (BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        phase;
      int          adc;
      logic [14:0] exp_data;
   } vec_t;

   int          errors = 0;
   int          checks = 0;
   logic [16:0] exp_q[$];
   int          ev[32];
   logic        mpol;
   int          m_echo;
   logic        mon_en = 1'b0;
   logic        rnd_ready = 1'b0;
   vec_t        tbl[6];

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
      if (rnd_ready) OUT_READY = ($urandom_range(0, 3) != 0);
   endtask

   // Scoreboard: every accepted word must be the next one the model expects
   always @(negedge CLK) begin
      if (mon_en && RESET_n && OUT_VALID && OUT_READY) begin
         if (exp_q.size() == 0) check("unexpected_word", {15'd0, OUT_EOP, OUT_SOP, OUT_DATA}, 32'd0);
         else check("stream_word", {15'd0, OUT_EOP, OUT_SOP, OUT_DATA}, {15'd0, exp_q.pop_front()});
      end
   end

   task automatic start_scan(input logic phase);
      FSMSTAT = 1'b0;
      tick();
      tick();
      PHASE_CYC = phase;
      FSMSTAT   = 1'b1;
      tick();
      mpol   = phase;
      m_echo = 0;
   endtask

   task automatic adc_edge(input int v);
      ADC_DATA = 14'(v);
      ADC_CLK  = 1'b1;
      tick();
      tick();
      ADC_CLK = 1'b0;
      tick();
      tick();
   endtask

   task automatic run_echo(input int n);
      ACQ_WND = 1'b1;
      tick();
      tick();
      for (int i = 0; i < n; i++) begin
         if (mon_en) exp_q.push_back({(i == n - 1), (i == 0), 15'(mpol ? ev[i] : -ev[i])});
         adc_edge(ev[i]);
      end
      ACQ_WND = 1'b0;
      tick();
      tick();
      tick();
      if (n > 0) m_echo++;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
      check("drain_timeout", exp_q.size(), 0);
   endtask

   initial begin
      RESET_n = 1'b0; FSMSTAT = 1'b0; ACQ_WND = 1'b0; ADC_CLK = 1'b0;
      PHASE_CYC = 1'b1; ADC_DATA = '0; OUT_READY = 1'b0; CLR_OVF = 1'b0;
      mpol = 1'b1; m_echo = 0;
      tick();
      tick();
      check("rst_valid", OUT_VALID, 0);
      check("rst_data", OUT_DATA, 0);
      check("rst_flags", {OUT_SOP, OUT_EOP}, 0);
      check("rst_echo", ECHO_IDX, 0);
      check("rst_ovf", OVERFLOW, 0);
      check("rst_busy", BUSY, 0);
      RESET_n = 1'b1;
      tick();
      check("idle_busy", BUSY, 0);

      // Table: one-sample echoes across polarity and range extremes
      tbl[0] = '{1'b1, -8192, 15'h6000};
      tbl[1] = '{1'b0, -8192, 15'h2000};
      tbl[2] = '{1'b0,  8191, 15'h6001};
      tbl[3] = '{1'b1,   100, 15'h0064};
      tbl[4] = '{1'b0,    -1, 15'h0001};
      tbl[5] = '{1'b1,    -5, 15'h7ffb};
      for (int t = 0; t < 6; t++) begin
         start_scan(tbl[t].phase);
         check("scan_echo_reset", ECHO_IDX, 0);
         ev[0] = tbl[t].adc;
         run_echo(1);
         check("tbl_valid", OUT_VALID, 1);
         check("tbl_data", OUT_DATA, tbl[t].exp_data);
         check("tbl_sop_eop", {OUT_SOP, OUT_EOP}, 2'b11);
         check("tbl_echo", ECHO_IDX, 1);
         OUT_READY = 1'b1;
         tick();
         OUT_READY = 1'b0;
         check("tbl_popped", OUT_VALID, 0);
      end

      // Single echo streamed through the scoreboard
      mon_en = 1'b1;
      OUT_READY = 1'b1;
      start_scan(1'b1);
      ev[0] = 100; ev[1] = 200; ev[2] = -5; ev[3] = 8191;
      run_echo(4);
      wait_drain();
      check("single_echo_idx", ECHO_IDX, 1);

      // Polarity is frozen for the scan even if PHASE_CYC changes
      start_scan(1'b0);
      ev[0] = -8192;
      run_echo(1);
      PHASE_CYC = 1'b1;
      ev[0] = 5; ev[1] = -7;
      run_echo(2);
      wait_drain();
      check("pol_echo_idx", ECHO_IDX, 2);

      // Three echoes of two samples, then a fresh scan clears the count
      start_scan(1'b1);
      for (int e = 0; e < 3; e++) begin
         ev[0] = 10 * e + 1; ev[1] = -(10 * e + 2);
         run_echo(2);
      end
      wait_drain();
      check("multi_echo_idx", ECHO_IDX, 3);

      // Window open one cycle with no ADC edge
      ACQ_WND = 1'b1;
      tick();
      ACQ_WND = 1'b0;
      tick(); tick(); tick();
      check("empty_wnd_valid", OUT_VALID, 0);
      check("empty_wnd_echo", ECHO_IDX, 3);
      start_scan(1'b1);
      check("rescan_echo_idx", ECHO_IDX, 0);

      // Randomized scans with random backpressure
      rnd_ready = 1'b1;
      for (int s = 0; s < 5; s++) begin
         start_scan(1'($urandom_range(0, 1)));
         for (int e = 0; e < int'($urandom_range(1, 3)); e++) begin
            for (int i = 0; i < 6; i++) ev[i] = int'($signed(14'($urandom_range(0, 16383))));
            run_echo(int'($urandom_range(0, 5)));
         end
         wait_drain();
         check("rnd_echo_idx", ECHO_IDX, m_echo);
         check("rnd_no_ovf", OVERFLOW, 0);
      end
      rnd_ready = 1'b0;
      mon_en    = 1'b0;
      OUT_READY = 1'b0;

      // Overflow: 20 samples into a 16-deep FIFO with no reader
      start_scan(1'b1);
      for (int i = 0; i < 20; i++) ev[i] = i + 1;
      run_echo(20);
      check("ovf_set", OVERFLOW, 1);
      check("ovf_echo_idx", ECHO_IDX, 1);
      for (int k = 0; k < 16; k++) begin
         check("ovf_valid", OUT_VALID, 1);
         check("ovf_data", OUT_DATA, k + 1);
         check("ovf_flags", {OUT_SOP, OUT_EOP}, {(k == 0), 1'b0});
         OUT_READY = 1'b1;
         tick();
         OUT_READY = 1'b0;
      end
      check("ovf_drained", OUT_VALID, 0);
      check("ovf_sticky", OVERFLOW, 1);
      CLR_OVF = 1'b1;
      tick();
      CLR_OVF = 1'b0;
      check("ovf_cleared", OVERFLOW, 0);

      // Reset mid-capture with five words queued
      start_scan(1'b1);
      ACQ_WND = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 6; i++) adc_edge(i + 40);
      check("pre_rst_valid", OUT_VALID, 1);
      check("pre_rst_busy", BUSY, 1);
      RESET_n = 1'b0;
      #1;
      check("mid_rst_valid", OUT_VALID, 0);
      check("mid_rst_data", OUT_DATA, 0);
      check("mid_rst_flags", {OUT_SOP, OUT_EOP}, 0);
      check("mid_rst_busy", BUSY, 0);
      check("mid_rst_echo", ECHO_IDX, 0);
      ACQ_WND = 1'b0; FSMSTAT = 1'b0; ADC_CLK = 1'b0;
      tick();
      RESET_n = 1'b1;
      tick();
      tick();
      check("post_rst_valid", OUT_VALID, 0);
      check("post_rst_busy", BUSY, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
